// File: rtl/multiword_add_seq.sv
// multiword_add_seq: wide add/subtract computed over NUM_SLICES cycles through one shared SLICE_W-bit adder slice
module multiword_add_seq #(
  parameter int SLICE_W = 4,
  parameter int NUM_SLICES = 4,
  localparam int OP_W = SLICE_W * NUM_SLICES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] op_a,
  input  logic [OP_W-1:0] op_b,
  input  logic            cin,
  input  logic            sub,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OP_W-1:0] sum,
  output logic            cout,
  output logic            overflow,
  output logic            busy
);
  localparam int IDX_W = NUM_SLICES > 1 ? $clog2(NUM_SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_SLICES - 1);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry, r_cout, r_ovf;
  logic [OP_W-1:0]    r_a, r_b, r_acc, r_sum;
  logic [SLICE_W-1:0] w_a_sl, w_b_sl, w_s;
  logic               w_c, w_cmsb;
  logic [OP_W-1:0]    w_acc;
  // carry into the MSB is recovered from the MSB sum bit: s = a ^ b ^ c_in
  always_comb begin
    w_a_sl = r_a[r_idx*SLICE_W +: SLICE_W];
    w_b_sl = r_b[r_idx*SLICE_W +: SLICE_W];
    {w_c, w_s} = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{SLICE_W{1'b0}}, r_carry};
    w_cmsb = w_a_sl[SLICE_W-1] ^ w_b_sl[SLICE_W-1] ^ w_s[SLICE_W-1];
    w_acc = r_acc;
    w_acc[r_idx*SLICE_W +: SLICE_W] = w_s;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_a     <= op_a;
          r_b     <= sub ? ~op_b : op_b;
          r_carry <= sub | cin;
          r_idx   <= '0;
          r_state <= RUN;
        end
        RUN: begin
          r_acc   <= w_acc;
          r_carry <= w_c;
          if (r_idx == LAST) begin
            r_sum   <= w_acc;
            r_cout  <= w_c;
            r_ovf   <= w_cmsb ^ w_c;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: if (out_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign in_ready  = r_state == IDLE;
  assign out_valid = r_state == DONE;
  assign busy      = r_state == RUN || r_state == DONE;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign overflow  = r_ovf;
endmodule

// File: tb/tb_multiword_add_seq.sv
// tb_multiword_add_seq: directed and random checks of the sliced wide adder/subtractor
module tb_multiword_add_seq;
  localparam int SW = 4;
  localparam int NS = 4;
  localparam int W = SW * NS;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, cin = 0, sub = 0;
  logic [W-1:0] op_a = '0, op_b = '0;
  logic in_ready, out_valid, cout, overflow, busy;
  logic [W-1:0] sum;
  int total = 0, bad = 0;

  multiword_add_seq #(.SLICE_W(SW), .NUM_SLICES(NS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic ci, input logic sb);
    logic [W:0] t;
    logic [W-1:0] s;
    logic c, ov;
    t  = sb ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    s  = t[W-1:0];
    c  = sb ? (a >= b) : t[W];
    ov = sb ? (a[W-1] != b[W-1] && s[W-1] != a[W-1]) : (a[W-1] == b[W-1] && s[W-1] != a[W-1]);
    return {c, ov, s};
  endfunction

  task automatic wait_done(input string tag);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, NS);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic sb,
                        input logic [W-1:0] es, input logic ec, input logic eo);
    check({tag, "_in_ready"}, in_ready, 1);
    op_a = a; op_b = b; cin = ci; sub = sb; in_valid = 1;
    @(negedge clk);
    in_valid = 0; op_a = ~a; op_b = ~b; cin = ~ci; sub = ~sb;
    check({tag, "_busy"}, busy, 1);
    wait_done(tag);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_ovf"}, overflow, eo);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    check({tag, "_release"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    logic seen;
    logic [W-1:0] a, b;
    logic ci, sb;
    logic [W+1:0] e;
    repeat (2) @(negedge clk);
    check("rst_outs", {out_valid, busy, in_ready, cout, overflow}, 5'b00100);
    check("rst_sum", sum, 0);
    rst_n = 1;
    @(negedge clk);
    run_op("wrap", 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0);
    run_op("posovf", 16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1);
    run_op("cin", 16'h1234, 16'h4321, 1, 0, 16'h5556, 0, 0);
    run_op("sub_neg", 16'h0005, 16'h0007, 1, 1, 16'hFFFE, 0, 0);
    run_op("sub_ovf", 16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1);
    // backpressure in DONE while a new request waits
    op_a = 16'h0100; op_b = 16'h0200; cin = 0; sub = 0; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    wait_done("hold");
    op_a = 16'h1111; op_b = 16'h1111; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_stable", {out_valid, in_ready, sum}, {2'b10, 16'h0300});
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    check("hold_idle", {out_valid, in_ready}, 2'b01);
    @(negedge clk);
    in_valid = 0;
    check("hold_next_busy", busy, 1);
    wait_done("hold_next");
    check("hold_next_sum", sum, 16'h2222);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    // reset while RUN is on slice 2
    op_a = 16'h1234; op_b = 16'h1111; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (2) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    check("abort_outs", {out_valid, busy, in_ready}, 3'b001);
    check("abort_sum", sum, 0);
    rst_n = 1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen |= out_valid;
    end
    check("abort_no_result", seen, 0);
    // back-to-back random operations
    in_valid = 1;
    out_ready = 1;
    for (int i = 0; i < 1000; i++) begin
      a = W'($urandom); b = W'($urandom); ci = 1'($urandom); sb = 1'($urandom);
      op_a = a; op_b = b; cin = ci; sub = sb;
      e = ref_op(a, b, ci, sb);
      @(negedge clk);
      wait_done("rand");
      check("rand_result", {cout, overflow, sum}, e);
      @(negedge clk);
      check("rand_spacing", in_ready, 1);
    end
    in_valid = 0;
    out_ready = 0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
